switch_allocator: RTL

Per-output round-robin switch allocator for the 5-port router crossbar. It takes one-hot output-port requests from the five input ports and produces registered one-hot select vectors sel0..sel4. These drive the crossbar's select inputs directly: bit j of selk routes input j to output k. Under wormhole operation it holds an output for a packet until the tail flit is transferred. It also returns a per-input grant so input buffers know when to advance.

---
 rtl/router_pkg.sv | 27 ++
 rtl/switch_allocator_if.sv | 20 ++
 rtl/switch_allocator_rr_arbiter5.sv | 34 +++
 rtl/switch_allocator.sv | 117 +++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: port count, one-hot port vector type, port index
// constants, allocator FSM state type and a one-hot validity helper.
package router_pkg;

   // Fixed at 5 to match the crossbar; other values are not supported.
   localparam int NPORTS = 5;

   typedef logic [NPORTS-1:0] port_vec_t;
   typedef logic [2:0]        port_idx_t;

   localparam port_idx_t PORT_LOCAL = 3'd0;
   localparam port_idx_t PORT_N     = 3'd1;
   localparam port_idx_t PORT_E     = 3'd2;
   localparam port_idx_t PORT_S     = 3'd3;
   localparam port_idx_t PORT_W     = 3'd4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } sa_state_t;

   // True when exactly one bit of v is set.
   function automatic logic onehot_valid(input port_vec_t v);
      return (v != '0) && ((v & (v - port_vec_t'(1))) == '0);
   endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Allocator handshake bundle.
//   req[i]  : one-hot output request from input i
//   tail[i] : flit offered by input i is a tail / single-flit flit
//   sel[k]  : registered one-hot crossbar select for output k
//   gnt[i]  : registered, input i owns an output this cycle
//   busy[k] : registered, output k is allocated
// master = input-port side, slave = allocator.
interface switch_allocator_if;
   import router_pkg::*;

   port_vec_t [NPORTS-1:0] req;
   logic      [NPORTS-1:0] tail;
   port_vec_t [NPORTS-1:0] sel;
   logic      [NPORTS-1:0] gnt;
   port_vec_t              busy;

   modport master (output req, tail, input sel, gnt, busy);
   modport slave  (input req, tail, output sel, gnt, busy);

endinterface

// File: rtl/switch_allocator_rr_arbiter5.sv
// rr_arbiter5: combinational 5-input round-robin arbiter.
//   i_req : request vector
//   i_ptr : index of the last winner (lowest priority this round)
//   o_gnt : one-hot grant, zero when no request
//   o_idx : encoded index of the winner (i_ptr when no request)
module rr_arbiter5
   import router_pkg::*;
(
   input  port_vec_t i_req,
   input  port_idx_t i_ptr,
   output port_vec_t o_gnt,
   output port_idx_t o_idx
);

   logic w_found;
   int   w_cand;

   // Search upward from i_ptr+1 with wrap; i_ptr itself is visited last.
   always_comb begin
      o_gnt   = '0;
      o_idx   = i_ptr;
      w_found = 1'b0;
      w_cand  = 0;
      for (int n = 1; n <= NPORTS; n++) begin
         w_cand = (int'(i_ptr) + n) % NPORTS;
         if (!w_found && i_req[w_cand]) begin
            w_found        = 1'b1;
            o_gnt[w_cand]  = 1'b1;
            o_idx          = port_idx_t'(w_cand);
         end
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin allocator for the 5-port crossbar.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   sa    : switch_allocator_if.slave (req/tail in, sel/gnt/busy out)
// Build option SA_WORMHOLE_EN: when defined an output stays locked to its
// owner until the tail flit transfers or the owner drops its request; when
// undefined every output re-arbitrates every cycle and tail is ignored.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | output free, arbitrate among legal requesters
// ST_HELD | output owned by input r_ptr[k]; hold until release
module switch_allocator
   import router_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   switch_allocator_if.slave sa
);

`ifdef SA_WORMHOLE_EN
   localparam bit C_LOCK = 1'b1;
`else
   localparam bit C_LOCK = 1'b0;
`endif

   sa_state_t r_state [NPORTS];
   port_idx_t r_ptr   [NPORTS];
   port_vec_t r_sel   [NPORTS];
   port_vec_t r_gnt;
   port_vec_t r_busy;

   sa_state_t w_state_nxt [NPORTS];
   port_idx_t w_ptr_nxt   [NPORTS];
   port_vec_t w_sel_nxt   [NPORTS];
   port_vec_t w_req_k     [NPORTS];
   port_vec_t w_arb_gnt   [NPORTS];
   port_idx_t w_arb_idx   [NPORTS];
   port_vec_t w_legal;
   port_vec_t w_gnt_nxt;
   port_vec_t w_busy_nxt;
   logic      w_rel       [NPORTS];

   // Transpose requests into per-output vectors; multi-hot requests vanish.
   always_comb begin
      for (int i = 0; i < NPORTS; i++) begin
         w_legal[i] = onehot_valid(sa.req[i]);
      end
      for (int k = 0; k < NPORTS; k++) begin
         w_req_k[k] = '0;
         for (int i = 0; i < NPORTS; i++) begin
            w_req_k[k][i] = w_legal[i] & sa.req[i][k];
         end
      end
   end

   for (genvar k = 0; k < NPORTS; k++) begin : g_arb
      rr_arbiter5 u_arb (
         .i_req (w_req_k[k]),
         .i_ptr (r_ptr[k]),
         .o_gnt (w_arb_gnt[k]),
         .o_idx (w_arb_idx[k])
      );
   end

   // While held, r_ptr[k] is the owner, so arbitrating on release with the
   // same pointer gives the previous owner lowest priority.
   always_comb begin
      w_gnt_nxt  = '0;
      w_busy_nxt = '0;
      for (int k = 0; k < NPORTS; k++) begin
         w_state_nxt[k] = r_state[k];
         w_ptr_nxt[k]   = r_ptr[k];
         w_sel_nxt[k]   = r_sel[k];
         w_rel[k]       = !w_req_k[k][r_ptr[k]] ||
                          (r_gnt[r_ptr[k]] && sa.tail[r_ptr[k]]);
         if (!(C_LOCK && (r_state[k] == ST_HELD) && !w_rel[k])) begin
            w_sel_nxt[k] = w_arb_gnt[k];
            if (w_arb_gnt[k] != '0) begin
               w_ptr_nxt[k]   = w_arb_idx[k];
               w_state_nxt[k] = C_LOCK ? ST_HELD : ST_IDLE;
            end else begin
               w_state_nxt[k] = ST_IDLE;
            end
         end
         w_gnt_nxt     = w_gnt_nxt | w_sel_nxt[k];
         w_busy_nxt[k] = |w_sel_nxt[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NPORTS; k++) begin
            r_state[k] <= ST_IDLE;
            r_ptr[k]   <= PORT_W;
            r_sel[k]   <= '0;
         end
         r_gnt  <= '0;
         r_busy <= '0;
      end else begin
         for (int k = 0; k < NPORTS; k++) begin
            r_state[k] <= w_state_nxt[k];
            r_ptr[k]   <= w_ptr_nxt[k];
            r_sel[k]   <= w_sel_nxt[k];
         end
         r_gnt  <= w_gnt_nxt;
         r_busy <= w_busy_nxt;
      end
   end

   for (genvar k = 0; k < NPORTS; k++) begin : g_out
      assign sa.sel[k] = r_sel[k];
   end
   assign sa.gnt  = r_gnt;
   assign sa.busy = r_busy;

endmodule
